layer_mixer: RTL and testbench



---
 rtl/layer_mixer.sv | 196 +++++++++++++++++++
 tb/tb_layer_mixer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/layer_mixer.sv
// N-layer priority pixel compositor with per-frame layer-0 overlap detection.
// Optional macro LAYER_MIXER_BLEND_EN averages the two highest-priority opaque layers.
module layer_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W = 8,
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = 24'h4169E1
) (
  input  logic                              CLOCK_50,
  input  logic                              reset,
  input  logic [9:0]                        x,
  input  logic [8:0]                        y,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [NUM_LAYERS-1:0]             layer_hit,
  input  logic [NUM_LAYERS-1:0]             layer_en,
  output logic [COLOR_W-1:0]                r,
  output logic [COLOR_W-1:0]                g,
  output logic [COLOR_W-1:0]                b,
  output logic [2:0]                        top_layer,
  output logic                              frame_done,
  output logic                              collision,
  output logic [7:0]                        collision_frames
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam logic [2:0] BG_IDX = 3'(NUM_LAYERS);
  localparam logic [9:0] X_END  = 10'(WIDTH);
  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_END  = 9'(HEIGHT);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  logic                  s1_valid_r;
  logic [9:0]            s1_x_r;
  logic [8:0]            s1_y_r;
  logic [9:0]            prev_x_r;
  logic [8:0]            prev_y_r;
  logic [NUM_LAYERS*PIX_W-1:0] s1_rgb_r;
  logic [NUM_LAYERS-1:0] s1_eff_r;
  logic                  acc_r;
  logic [PIX_W-1:0]      rgb_r;

  logic [2:0]            win_s;
  logic                  any_s;
  logic [PIX_W-1:0]      win_rgb_s;
  logic [PIX_W-1:0]      mix_s;
  logic                  visible_s;
  logic                  overlap_s;
  logic                  frame_end_s;
  logic                  frame_hit_s;

  // Lowest enabled opaque index wins; the loop runs downward so index 0 is taken last.
  always_comb begin
    win_s     = BG_IDX;
    any_s     = 1'b0;
    win_rgb_s = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_eff_r[i]) begin
        win_s     = 3'(i);
        any_s     = 1'b1;
        win_rgb_s = s1_rgb_r[i*PIX_W +: PIX_W];
      end else begin
        win_s     = win_s;
      end
    end
  end

`ifdef LAYER_MIXER_BLEND_EN
  logic             has_sec_s;
  logic [PIX_W-1:0] sec_rgb_s;

  function automatic logic [COLOR_W-1:0] chan_avg(input logic [COLOR_W-1:0] a,
                                                  input logic [COLOR_W-1:0] c);
    logic [COLOR_W:0] sum;
    sum = {1'b0, a} + {1'b0, c};
    return sum[COLOR_W:1];
  endfunction

  // Runner-up layer: next-lowest set index after the winner.
  always_comb begin
    has_sec_s = 1'b0;
    sec_rgb_s = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_eff_r[i] && (3'(i) != win_s)) begin
        has_sec_s = 1'b1;
        sec_rgb_s = s1_rgb_r[i*PIX_W +: PIX_W];
      end else begin
        has_sec_s = has_sec_s;
      end
    end
  end

  // Colour selection with two-layer averaging.
  always_comb begin
    mix_s = BG_COLOR;
    if (any_s && has_sec_s) begin
      for (int c = 0; c < 3; c++) begin
        mix_s[c*COLOR_W +: COLOR_W] = chan_avg(win_rgb_s[c*COLOR_W +: COLOR_W],
                                               sec_rgb_s[c*COLOR_W +: COLOR_W]);
      end
    end else if (any_s) begin
      mix_s = win_rgb_s;
    end else begin
      mix_s = BG_COLOR;
    end
  end
`else
  // Colour selection, pure opaque priority.
  always_comb begin
    mix_s = BG_COLOR;
    if (any_s) begin
      mix_s = win_rgb_s;
    end else begin
      mix_s = BG_COLOR;
    end
  end
`endif

  // Visibility, overlap and end-of-frame are all judged on stage-1 coordinates.
  always_comb begin
    visible_s   = (s1_x_r < X_END) && (s1_y_r < Y_END);
    overlap_s   = s1_valid_r && visible_s && s1_eff_r[0] &&
                  (|s1_eff_r[NUM_LAYERS-1:1]);
    frame_end_s = s1_valid_r && (s1_x_r == X_LAST) && (s1_y_r == Y_LAST) &&
                  ((s1_x_r != prev_x_r) || (s1_y_r != prev_y_r));
    frame_hit_s = acc_r || overlap_s;
  end

  // Stage 1 capture plus previous-coordinate tracking for held pixels.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_x_r     <= 10'd0;
      s1_y_r     <= 9'd0;
      prev_x_r   <= 10'd0;
      prev_y_r   <= 9'd0;
      s1_rgb_r   <= '0;
      s1_eff_r   <= '0;
    end else begin
      s1_valid_r <= 1'b1;
      s1_x_r     <= x;
      s1_y_r     <= y;
      prev_x_r   <= s1_x_r;
      prev_y_r   <= s1_y_r;
      s1_rgb_r   <= layer_rgb;
      s1_eff_r   <= layer_hit & layer_en;
    end
  end

  // Stage 2 output colour and winning index.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rgb_r     <= BG_COLOR;
      top_layer <= BG_IDX;
    end else if (!s1_valid_r) begin
      rgb_r     <= BG_COLOR;
      top_layer <= BG_IDX;
    end else if (!visible_s) begin
      rgb_r     <= '0;
      top_layer <= BG_IDX;
    end else begin
      rgb_r     <= mix_s;
      top_layer <= any_s ? win_s : BG_IDX;
    end
  end

  // Frame-level collision: final-pixel overlap is folded in before the accumulator clears.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_done       <= 1'b0;
      collision        <= 1'b0;
      collision_frames <= 8'd0;
      acc_r            <= 1'b0;
    end else begin
      frame_done <= frame_end_s;
      if (frame_end_s) begin
        collision <= frame_hit_s;
        acc_r     <= 1'b0;
        if (frame_hit_s && (collision_frames != 8'hFF)) begin
          collision_frames <= collision_frames + 8'd1;
        end else begin
          collision_frames <= collision_frames;
        end
      end else if (overlap_s) begin
        acc_r <= 1'b1;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign r = rgb_r[3*COLOR_W-1 -: COLOR_W];
  assign g = rgb_r[2*COLOR_W-1 -: COLOR_W];
  assign b = rgb_r[COLOR_W-1:0];

endmodule

// File: tb/tb_layer_mixer.sv
// Directed self-checking bench for layer_mixer (default 4 layers, 8-bit colour).
module tb_layer_mixer;

  logic        CLOCK_50;
  logic        reset;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [95:0] layer_rgb;
  logic [3:0]  layer_hit;
  logic [3:0]  layer_en;
  logic [7:0]  r, g, b;
  logic [2:0]  top_layer;
  logic        frame_done;
  logic        collision;
  logic [7:0]  collision_frames;

  int total = 0;
  int bad   = 0;

  layer_mixer dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .x(x), .y(y),
    .layer_rgb(layer_rgb), .layer_hit(layer_hit), .layer_en(layer_en),
    .r(r), .g(g), .b(b), .top_layer(top_layer), .frame_done(frame_done),
    .collision(collision), .collision_frames(collision_frames)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One short frame: a pixel at (ox,oy), then the last pixel, then back to origin.
  task automatic frame(input logic [9:0] ox, input logic [8:0] oy, input logic [3:0] ohit);
    x = ox; y = oy; layer_hit = ohit;
    tick();
    x = 10'd639; y = 9'd479; layer_hit = 4'b0000;
    tick();
    x = 10'd0; y = 9'd0; layer_hit = 4'b0000;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    x = 10'd100; y = 9'd100;
    layer_rgb = {24'h123456, 24'h00FF00, 24'hFF0000, 24'h0000FF};
    layer_hit = 4'b1111; layer_en = 4'b1111;
    tick(); tick(); tick();
    check("rst_r", 32'(r), 32'd65);
    check("rst_g", 32'(g), 32'd105);
    check("rst_b", 32'(b), 32'd225);
    check("rst_top", 32'(top_layer), 32'd4);
    check("rst_coll", 32'(collision), 32'd0);
    check("rst_cnt", 32'(collision_frames), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);

    reset = 1'b0;
    layer_hit = 4'b0110;
    tick(); tick();
`ifdef LAYER_MIXER_BLEND_EN
    check("prio_r", 32'(r), 32'h7F);
    check("prio_g", 32'(g), 32'h7F);
`else
    check("prio_r", 32'(r), 32'hFF);
    check("prio_g", 32'(g), 32'h00);
`endif
    check("prio_b", 32'(b), 32'h00);
    check("prio_top", 32'(top_layer), 32'd1);

    layer_en = 4'b1101;
    tick();
    check("latency_hold_top", 32'(top_layer), 32'd1);
    tick();
    check("en_r", 32'(r), 32'h00);
    check("en_g", 32'(g), 32'hFF);
    check("en_b", 32'(b), 32'h00);
    check("en_top", 32'(top_layer), 32'd2);

    layer_en = 4'b1111; layer_hit = 4'b0000;
    tick(); tick();
    check("bg_rgb", {8'd0, r, g, b}, 32'h004169E1);
    check("bg_top", 32'(top_layer), 32'd4);

    x = 10'd700; y = 9'd50; layer_hit = 4'b0001;
    tick(); tick();
    check("blank_rgb", {8'd0, r, g, b}, 32'h0);
    check("blank_top", 32'(top_layer), 32'd4);
    check("blank_fd", 32'(frame_done), 32'd0);

    frame(10'd10, 9'd10, 4'b0011);
    check("coll_fd", 32'(frame_done), 32'd1);
    check("coll_flag", 32'(collision), 32'd1);
    check("coll_cnt", 32'(collision_frames), 32'd1);
    tick();
    check("coll_fd_pulse", 32'(frame_done), 32'd0);
    check("coll_hold", 32'(collision), 32'd1);

    frame(10'd5, 9'd5, 4'b0001);
    check("clean_fd", 32'(frame_done), 32'd1);
    check("clean_flag", 32'(collision), 32'd0);
    check("clean_cnt", 32'(collision_frames), 32'd1);

    x = 10'd5; y = 9'd5; layer_hit = 4'b0000;
    tick();
    x = 10'd639; y = 9'd479; layer_hit = 4'b0011;
    tick();
    x = 10'd0; y = 9'd0; layer_hit = 4'b0000;
    tick();
    check("edge_fd", 32'(frame_done), 32'd1);
    check("edge_flag", 32'(collision), 32'd1);
    check("edge_cnt", 32'(collision_frames), 32'd2);

    for (int i = 0; i < 256; i++) begin
      frame(10'd10, 9'd10, 4'b0011);
    end
    check("sat_cnt", 32'(collision_frames), 32'd255);

    layer_rgb = {24'h123456, 24'h00FF00, 24'h010000, 24'hFF0000};
    x = 10'd100; y = 9'd100; layer_hit = 4'b0011;
    tick(); tick();
`ifdef LAYER_MIXER_BLEND_EN
    check("blend_r", 32'(r), 32'h80);
`else
    check("blend_r", 32'(r), 32'hFF);
`endif
    check("blend_top", 32'(top_layer), 32'd0);

    reset = 1'b1; layer_hit = 4'b0000;
    tick();
    check("midrst_coll", 32'(collision), 32'd0);
    check("midrst_cnt", 32'(collision_frames), 32'd0);
    check("midrst_top", 32'(top_layer), 32'd4);
    reset = 1'b0;
    frame(10'd5, 9'd5, 4'b0000);
    check("post_rst_fd", 32'(frame_done), 32'd1);
    check("post_rst_flag", 32'(collision), 32'd0);
    check("post_rst_cnt", 32'(collision_frames), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
